// File: rtl/intersection_phase_scheduler.sv
// Traffic-intersection phase scheduler: main road rests in green, minor phases
// (turn, side, pedestrian) are granted round-robin from latched requests, and
// an emergency input preempts toward main-road green.
//
// state | code | meaning
// ------+------+------------------------------------------------
// AR    | 0    | all red clearance; leaves to the phase in target
// MG    | 1    | main road green (rest state, minimum T_MAIN)
// MY    | 2    | main road yellow
// TG    | 3    | main turn green
// TY    | 4    | main turn yellow
// SG    | 5    | side road green
// SY    | 6    | side road yellow
// PW    | 7    | pedestrian walk
module intersection_phase_scheduler #(
    parameter int unsigned T_MAIN = 20,
    parameter int unsigned T_TURN = 10,
    parameter int unsigned T_SIDE = 15,
    parameter int unsigned T_PED  = 12,
    parameter int unsigned T_YEL  = 4,
    parameter int unsigned T_AR   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       turn_req,
    input  logic       side_req,
    input  logic       ped_req,
    input  logic       emg_req,
    output logic [2:0] M1,
    output logic [2:0] M2,
    output logic [2:0] MT,
    output logic [2:0] S,
    output logic       walk,
    output logic [2:0] pending,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_AR = 4'd0,
        ST_MG = 4'd1,
        ST_MY = 4'd2,
        ST_TG = 4'd3,
        ST_TY = 4'd4,
        ST_SG = 4'd5,
        ST_SY = 4'd6,
        ST_PW = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        TGT_MAIN = 2'd0,
        TGT_TURN = 2'd1,
        TGT_SIDE = 2'd2,
        TGT_PED  = 2'd3
    } target_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [7:0] LD_MAIN = 8'(T_MAIN - 1);
    localparam logic [7:0] LD_TURN = 8'(T_TURN - 1);
    localparam logic [7:0] LD_SIDE = 8'(T_SIDE - 1);
    localparam logic [7:0] LD_PED  = 8'(T_PED - 1);
    localparam logic [7:0] LD_YEL  = 8'(T_YEL - 1);
    localparam logic [7:0] LD_AR   = 8'(T_AR - 1);

    state_t     cur, nxt;
    target_t    target, target_nxt, target_eff;
    logic [7:0] count, load_val;
    logic       expired;
    logic [1:0] rr_ptr, rr_ptr_nxt;
    logic [2:0] pending_nxt;
    logic [2:0] slot;
    logic       grant_found;
    logic [1:0] grant_idx;

    assign expired = (count == 8'd0);
    assign state   = cur;

    // Round-robin search over pending {ped, side, turn}, starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 2'd0;
        slot        = 3'd0;
        for (int i = 0; i < 3; i++) begin
            slot = {1'b0, rr_ptr} + 3'(i);
            if (slot >= 3'd3) slot = slot - 3'd3;
            if (!grant_found && pending[slot[1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = slot[1:0];
            end
        end
    end

    // Next-state, target and round-robin pointer decisions.
    always_comb begin
        nxt        = cur;
        target_nxt = target;
        rr_ptr_nxt = rr_ptr;
        // Emergency overrides the pending destination while clearing toward AR.
        target_eff = emg_req ? TGT_MAIN : target;
        case (cur)
            ST_MG: begin
                if (!emg_req && expired && grant_found) begin
                    nxt        = ST_MY;
                    target_nxt = target_t'(2'(grant_idx + 2'd1));
                    rr_ptr_nxt = (grant_idx == 2'd2) ? 2'd0 : 2'(grant_idx + 2'd1);
                end
            end
            ST_MY: begin
                target_nxt = target_eff;
                if (expired) nxt = ST_AR;
            end
            ST_AR: begin
                target_nxt = target_eff;
                if (expired) begin
                    case (target_eff)
                        TGT_MAIN: nxt = ST_MG;
                        TGT_TURN: nxt = ST_TG;
                        TGT_SIDE: nxt = ST_SG;
                        default:  nxt = ST_PW;
                    endcase
                end
            end
            ST_TG: begin
                if (emg_req || expired) begin
                    nxt        = ST_TY;
                    target_nxt = TGT_MAIN;
                end
            end
            ST_SG: begin
                if (emg_req || expired) begin
                    nxt        = ST_SY;
                    target_nxt = TGT_MAIN;
                end
            end
            ST_PW: begin
                if (emg_req || expired) begin
                    nxt        = ST_AR;
                    target_nxt = TGT_MAIN;
                end
            end
            ST_TY, ST_SY: begin
                if (expired) begin
                    nxt        = ST_AR;
                    target_nxt = TGT_MAIN;
                end
            end
            default: begin
                nxt        = ST_AR;
                target_nxt = TGT_MAIN;
            end
        endcase
    end

    // Duration reload value for the state being entered.
    always_comb begin
        case (nxt)
            ST_MG:        load_val = LD_MAIN;
            ST_TG:        load_val = LD_TURN;
            ST_SG:        load_val = LD_SIDE;
            ST_PW:        load_val = LD_PED;
            ST_MY, ST_TY,
            ST_SY:        load_val = LD_YEL;
            default:      load_val = LD_AR;
        endcase
    end

    // Request latches: entering a request's green clears it and swallows a
    // request arriving in that same cycle.
    always_comb begin
        pending_nxt = pending | {ped_req, side_req, turn_req};
        if (nxt == ST_TG && cur != ST_TG) pending_nxt[0] = 1'b0;
        if (nxt == ST_SG && cur != ST_SG) pending_nxt[1] = 1'b0;
        if (nxt == ST_PW && cur != ST_PW) pending_nxt[2] = 1'b0;
    end

    // State, timer, target, pointer and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur     <= ST_AR;
            count   <= LD_AR;
            target  <= TGT_MAIN;
            rr_ptr  <= 2'd0;
            pending <= 3'b000;
        end else begin
            cur     <= nxt;
            target  <= target_nxt;
            rr_ptr  <= rr_ptr_nxt;
            pending <= pending_nxt;
            if (nxt != cur) count <= load_val;
            else if (!expired) count <= count - 8'd1;
        end
    end

    // Moore lamp decode; anything not explicitly lit stays red.
    always_comb begin
        M1   = LAMP_RED;
        M2   = LAMP_RED;
        MT   = LAMP_RED;
        S    = LAMP_RED;
        walk = 1'b0;
        case (cur)
            ST_MG: begin M1 = LAMP_GRN; M2 = LAMP_GRN; end
            ST_MY: begin M1 = LAMP_YEL; M2 = LAMP_YEL; end
            ST_TG: MT = LAMP_GRN;
            ST_TY: MT = LAMP_YEL;
            ST_SG: S = LAMP_GRN;
            ST_SY: S = LAMP_YEL;
            ST_PW: walk = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Scoreboard bench: a phase-level reference model predicts lamps, walk,
// pending and state each cycle; a negedge monitor compares the DUT.
module tb_intersection_phase_scheduler;

    localparam int T_MAIN = 20, T_TURN = 10, T_SIDE = 15, T_PED = 12, T_YEL = 4, T_AR = 2;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    logic clk = 1'b0, rst = 1'b0;
    logic turn_req = 1'b0, side_req = 1'b0, ped_req = 1'b0, emg_req = 1'b0;
    logic [2:0] M1, M2, MT, S, pending;
    logic walk;
    logic [3:0] state;

    intersection_phase_scheduler #(
        .T_MAIN(T_MAIN), .T_TURN(T_TURN), .T_SIDE(T_SIDE),
        .T_PED(T_PED), .T_YEL(T_YEL), .T_AR(T_AR)
    ) dut (
        .clk(clk), .rst(rst), .turn_req(turn_req), .side_req(side_req),
        .ped_req(ped_req), .emg_req(emg_req), .M1(M1), .M2(M2), .MT(MT),
        .S(S), .walk(walk), .pending(pending), .state(state)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    logic [19:0] exp_q[$];

    // Reference model: phase, cycles spent in it, destination after all-red
    // (0 main, 1 turn, 2 side, 3 ped), latched requests and priority order.
    typedef enum int {P_AR, P_MG, P_MY, P_TG, P_TY, P_SG, P_SY, P_PW} phase_e;
    phase_e ph;
    int elapsed, dest;
    bit [2:0] pend;
    int rr[$];

    function automatic int dur(phase_e p);
        case (p)
            P_AR: return T_AR;
            P_MG: return T_MAIN;
            P_TG: return T_TURN;
            P_SG: return T_SIDE;
            P_PW: return T_PED;
            default: return T_YEL;
        endcase
    endfunction

    function automatic phase_e green_of(int i);
        if (i == 0) return P_TG;
        if (i == 1) return P_SG;
        return P_PW;
    endfunction

    function automatic logic [19:0] expect_vec();
        logic [2:0] m, t, s;
        logic w;
        logic [3:0] code;
        m = RED; t = RED; s = RED; w = 1'b0; code = 4'd0;
        case (ph)
            P_AR: code = 4'd0;
            P_MG: begin m = GRN; code = 4'd1; end
            P_MY: begin m = YEL; code = 4'd2; end
            P_TG: begin t = GRN; code = 4'd3; end
            P_TY: begin t = YEL; code = 4'd4; end
            P_SG: begin s = GRN; code = 4'd5; end
            P_SY: begin s = YEL; code = 4'd6; end
            P_PW: begin w = 1'b1; code = 4'd7; end
            default: ;
        endcase
        return {m, m, t, s, w, pend, code};
    endfunction

    task automatic model_reset();
        ph = P_AR; elapsed = 1; dest = 0; pend = 3'b000;
        rr = {0, 1, 2};
    endtask

    task automatic model_step(input bit t, input bit s, input bit p, input bit e);
        phase_e nx;
        bit expd;
        int g, x;
        bit [2:0] r;
        nx = ph;
        expd = (elapsed >= dur(ph));
        case (ph)
            P_MG: if (!e && expd && pend != 3'b000) begin
                g = -1;
                foreach (rr[k]) if (g < 0 && pend[rr[k]]) g = rr[k];
                do begin x = rr.pop_front(); rr.push_back(x); end while (x != g);
                dest = g + 1;
                nx = P_MY;
            end
            P_MY: begin if (e) dest = 0; if (expd) nx = P_AR; end
            P_AR: begin
                if (e) dest = 0;
                if (expd) nx = (dest == 0) ? P_MG : green_of(dest - 1);
            end
            P_TG: if (e || expd) begin nx = P_TY; dest = 0; end
            P_SG: if (e || expd) begin nx = P_SY; dest = 0; end
            P_PW: if (e || expd) begin nx = P_AR; dest = 0; end
            default: if (expd) begin nx = P_AR; dest = 0; end
        endcase
        r = {p, s, t};
        for (int i = 0; i < 3; i++) begin
            if (nx != ph && nx == green_of(i)) pend[i] = 1'b0;
            else if (r[i]) pend[i] = 1'b1;
        end
        elapsed = (nx != ph) ? 1 : elapsed + 1;
        ph = nx;
    endtask

    task automatic cycle(input bit t, input bit s, input bit p, input bit e);
        turn_req = t; side_req = s; ped_req = p; emg_req = e;
        exp_q.push_back(expect_vec());
        model_step(t, s, p, e);
        @(posedge clk); #1;
    endtask

    task automatic hold_reset(input int n);
        logic [19:0] act;
        rst = 1'b0;
        turn_req = 0; side_req = 0; ped_req = 0; emg_req = 0;
        model_reset();
        #1;
        act = {M1, M2, MT, S, walk, pending, state};
        vectors++;
        if (act !== expect_vec()) begin
            miscompares++;
            $display("FAIL async_reset t=%0t actual=%b required=%b", $time, act, expect_vec());
        end
        repeat (n) begin
            exp_q.push_back(expect_vec());
            @(posedge clk); #1;
        end
        rst = 1'b1;
    endtask

    task automatic run_until(input phase_e p, input int el, input int budget, input bit e, input string tag);
        int b;
        b = budget;
        while (!(ph == p && elapsed == el)) begin
            if (b == 0) begin
                vectors++; miscompares++;
                $display("FAIL timeout_%s actual phase=%0d required phase=%0d", tag, ph, p);
                return;
            end
            cycle(0, 0, 0, e);
            b--;
        end
    endtask

    // Scoreboard monitor: one expected vector per clock.
    logic [19:0] mon_e, mon_a;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {M1, M2, MT, S, walk, pending, state};
            vectors++;
            if (mon_a !== mon_e) begin
                miscompares++;
                $display("FAIL cycle t=%0t actual M1=%b M2=%b MT=%b S=%b walk=%b pend=%b state=%0d required M1=%b M2=%b MT=%b S=%b walk=%b pend=%b state=%0d",
                         $time, mon_a[19:17], mon_a[16:14], mon_a[13:11], mon_a[10:8], mon_a[7], mon_a[6:4], mon_a[3:0],
                         mon_e[19:17], mon_e[16:14], mon_e[13:11], mon_e[10:8], mon_e[7], mon_e[6:4], mon_e[3:0]);
            end
        end
    end

    // Conflict check every cycle: at most one approach group non-red, walk only
    // with everything red.
    logic main_on, turn_on, side_on;
    always @(negedge clk) begin
        main_on = (M1 != RED) || (M2 != RED);
        turn_on = (MT != RED);
        side_on = (S != RED);
        vectors++;
        assert ((int'(main_on) + int'(turn_on) + int'(side_on) <= 1) &&
                (!walk || !(main_on || turn_on || side_on)))
        else begin
            miscompares++;
            $display("FAIL conflict t=%0t actual M1=%b M2=%b MT=%b S=%b walk=%b required no conflicting lamps",
                     $time, M1, M2, MT, S, walk);
        end
    end

    int emg_left;
    initial begin
        model_reset();
        @(posedge clk); #1;

        // Power-up: AR then MG held with no requests.
        hold_reset(3);
        repeat (40) cycle(0, 0, 0, 0);

        // Single pedestrian request.
        cycle(0, 0, 1, 0);
        run_until(P_PW, 1, 100, 0, "ped");
        repeat (40) cycle(0, 0, 0, 0);

        // Simultaneous requests: turn, side, ped order.
        cycle(1, 1, 1, 0);
        run_until(P_TG, 1, 100, 0, "turn");
        run_until(P_SG, 1, 100, 0, "side");
        run_until(P_PW, 1, 100, 0, "ped2");
        repeat (40) cycle(0, 0, 0, 0);

        // Emergency during SG cycle 3 with side re-request while preempted.
        cycle(0, 1, 0, 0);
        run_until(P_SG, 3, 100, 0, "sg3");
        repeat (3) cycle(0, 0, 0, 1);
        cycle(0, 1, 0, 1);
        repeat (30) cycle(0, 0, 0, 1);
        run_until(P_SG, 1, 100, 0, "side_after_emg");
        repeat (30) cycle(0, 0, 0, 0);

        // Reset in the middle of TY.
        cycle(1, 0, 0, 0);
        run_until(P_TY, 2, 100, 0, "ty");
        hold_reset(3);
        repeat (40) cycle(0, 0, 0, 0);

        // Randomized traffic with emergency episodes and occasional resets.
        emg_left = 0;
        for (int n = 0; n < 4000; n++) begin
            if (emg_left > 0) emg_left--;
            else if ($urandom_range(0, 299) == 0) emg_left = $urandom_range(1, 40);
            if ($urandom_range(0, 1999) == 0) hold_reset($urandom_range(1, 3));
            else cycle($urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0,
                       $urandom_range(0, 39) == 0, emg_left > 0);
        end

        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
